// File: rtl/demux_1t2_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : demux_1t2_reg                                               |
// | Brief    : Registered 1-to-2 valid/ready demultiplexer; one output     |
// |            register per channel so each consumer stalls on its own.    |
// |            Optional delivery counters enabled by DEMUX_CNT_EN.         |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module demux_1t2_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic [15:0]      o0_count,
  output logic [15:0]      o1_count
);

  logic             r_ch0_valid;
  logic             r_ch1_valid;
  logic [WIDTH-1:0] r_ch0_data;
  logic [WIDTH-1:0] r_ch1_data;

  logic w_acc;
  logic w_del0;
  logic w_del1;

  // A channel can take a word when empty or when it is being drained this cycle.
  assign in_ready = s ? (~r_ch1_valid | o1_ready) : (~r_ch0_valid | o0_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_del0   = r_ch0_valid & o0_ready;
  assign w_del1   = r_ch1_valid & o1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch0_valid <= 1'b0;
      r_ch0_data  <= '0;
    end else if (w_acc && !s) begin
      r_ch0_valid <= 1'b1;
      r_ch0_data  <= in_data;
    end else if (w_del0) begin
      r_ch0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch1_valid <= 1'b0;
      r_ch1_data  <= '0;
    end else if (w_acc && s) begin
      r_ch1_valid <= 1'b1;
      r_ch1_data  <= in_data;
    end else if (w_del1) begin
      r_ch1_valid <= 1'b0;
    end
  end

  assign o0_valid = r_ch0_valid;
  assign o0_data  = r_ch0_data;
  assign o1_valid = r_ch1_valid;
  assign o1_data  = r_ch1_data;

`ifdef DEMUX_CNT_EN
  logic [15:0] r_ch0_count;
  logic [15:0] r_ch1_count;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch0_count <= 16'h0000;
      r_ch1_count <= 16'h0000;
    end else begin
      if (w_del0) r_ch0_count <= r_ch0_count + 16'h0001;
      if (w_del1) r_ch1_count <= r_ch1_count + 16'h0001;
    end
  end

  assign o0_count = r_ch0_count;
  assign o1_count = r_ch1_count;
`else
  assign o0_count = 16'h0000;
  assign o1_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1t2_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_demux_1t2_reg                                            |
// | Brief    : Directed scoreboard bench for demux_1t2_reg.                |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_demux_1t2_reg;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             s;
  logic             o0_valid;
  logic             o0_ready;
  logic [WIDTH-1:0] o0_data;
  logic             o1_valid;
  logic             o1_ready;
  logic [WIDTH-1:0] o1_data;
  logic [15:0]      o0_count;
  logic [15:0]      o1_count;

  demux_1t2_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .s        (s),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data),
    .o0_count (o0_count),
    .o1_count (o1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [15:0]      m_cnt0;
  logic [15:0]      m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input logic [15:0] model);
`ifdef DEMUX_CNT_EN
    return model;
`else
    return 16'h0000 & model;
`endif
  endfunction

  // Scoreboard sample point: deliveries pop and compare, acceptances push.
  task automatic sb_sample();
    logic [WIDTH-1:0] e;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 16'h0000;
      m_cnt1 = 16'h0000;
    end else begin
      if (o0_valid && o0_ready) begin
        if (q0.size() == 0) chk("ch0_unexpected_word", 32'(o0_data), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("ch0_data", 32'(o0_data), 32'(e));
        end
        m_cnt0 = m_cnt0 + 16'h0001;
      end
      if (o1_valid && o1_ready) begin
        if (q1.size() == 0) chk("ch1_unexpected_word", 32'(o1_data), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("ch1_data", 32'(o1_data), 32'(e));
        end
        m_cnt1 = m_cnt1 + 16'h0001;
      end
      if (in_valid && in_ready) begin
        if (s) q1.push_back(in_data);
        else   q0.push_back(in_data);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d);
    in_valid = v;
    s        = sel;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; s = 1'b0;
    o0_ready = 1'b1; o1_ready = 1'b1;
    m_cnt0 = 16'h0000; m_cnt1 = 16'h0000;
    @(posedge clk); #1;

    // T1: reset wins over an offered word
    drive(1'b1, 1'b0, 5'h1F);
    cyc();
    chk("t1_o0_valid", 32'(o0_valid), 32'd0);
    chk("t1_o1_valid", 32'(o1_valid), 32'd0);
    chk("t1_o0_data",  32'(o0_data),  32'd0);
    chk("t1_o1_data",  32'(o1_data),  32'd0);
    chk("t1_o0_count", 32'(o0_count), 32'd0);
    chk("t1_o1_count", 32'(o1_count), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'h00);
    cyc();

    // T2: steering to each channel
    drive(1'b1, 1'b0, 5'h0A);
    chk("t2_in_ready_a", 32'(in_ready), 32'd1);
    cyc();
    chk("t2_o0_valid", 32'(o0_valid), 32'd1);
    chk("t2_o0_data",  32'(o0_data),  32'h0A);
    chk("t2_o1_idle",  32'(o1_valid), 32'd0);
    drive(1'b1, 1'b1, 5'h15);
    chk("t2_in_ready_b", 32'(in_ready), 32'd1);
    cyc();
    chk("t2_o0_pulse", 32'(o0_valid), 32'd0);
    chk("t2_o1_valid", 32'(o1_valid), 32'd1);
    chk("t2_o1_data",  32'(o1_data),  32'h15);
    drive(1'b0, 1'b0, 5'h00);
    cyc();
    chk("t2_o1_pulse", 32'(o1_valid), 32'd0);
    chk("t2_o0_hold",  32'(o0_data),  32'h0A);

    // T3: stalled ch1 does not block ch0
    o1_ready = 1'b0;
    drive(1'b1, 1'b1, 5'h03);
    cyc();
    chk("t3_o1_valid", 32'(o1_valid), 32'd1);
    chk("t3_o1_data",  32'(o1_data),  32'h03);
    drive(1'b1, 1'b1, 5'h09);
    chk("t3_in_ready_stall", 32'(in_ready), 32'd0);
    cyc();
    chk("t3_o1_data_held", 32'(o1_data), 32'h03);
    drive(1'b1, 1'b0, 5'h04);
    chk("t3_in_ready_ch0", 32'(in_ready), 32'd1);
    cyc();
    chk("t3_o0_valid", 32'(o0_valid), 32'd1);
    chk("t3_o0_data",  32'(o0_data),  32'h04);
    drive(1'b0, 1'b0, 5'h00);
    cyc();
    chk("t3_o0_done",  32'(o0_valid), 32'd0);
    chk("t3_o1_still", 32'(o1_valid), 32'd1);
    o1_ready = 1'b1;
    cyc();
    chk("t3_o1_done",  32'(o1_valid), 32'd0);

    // T4: same-cycle drain and refill on ch0
    o0_ready = 1'b0;
    drive(1'b1, 1'b0, 5'h07);
    cyc();
    chk("t4_o0_data_a", 32'(o0_data), 32'h07);
    o0_ready = 1'b1;
    drive(1'b1, 1'b0, 5'h08);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("t4_o0_valid", 32'(o0_valid), 32'd1);
    chk("t4_o0_data_b", 32'(o0_data), 32'h08);
    drive(1'b0, 1'b0, 5'h00);
    cyc();
    chk("t4_o0_done", 32'(o0_valid), 32'd0);

    // T5: reset with both channels full discards both words
    o0_ready = 1'b0; o1_ready = 1'b0;
    drive(1'b1, 1'b0, 5'h11);
    cyc();
    drive(1'b1, 1'b1, 5'h12);
    cyc();
    chk("t5_full0", 32'(o0_valid), 32'd1);
    chk("t5_full1", 32'(o1_valid), 32'd1);
    drive(1'b0, 1'b0, 5'h00);
    o0_ready = 1'b1; o1_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_o0_valid", 32'(o0_valid), 32'd0);
    chk("t5_o1_valid", 32'(o1_valid), 32'd0);
    chk("t5_o0_count", 32'(o0_count), 32'd0);
    chk("t5_o1_count", 32'(o1_count), 32'd0);
    cyc();

    // T6: counter wrap after 65537 ch0 deliveries
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b0, 5'(i));
      cyc();
    end
    drive(1'b0, 1'b0, 5'h00);
    cyc();
    cyc();
    chk("t6_model_cnt0", 32'(m_cnt0), 32'd1);
    chk("t6_o0_count", 32'(o0_count), 32'(exp_cnt(m_cnt0)));
    chk("t6_o1_count", 32'(o1_count), 32'(exp_cnt(m_cnt1)));
    chk("t6_q0_empty", 32'(q0.size()), 32'd0);
    chk("t6_q1_empty", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
